axi_i2s_receiver: RTL and testbench

//  I2S receiver (slave) bridging to an AXI4-Stream master. Samples externally generated bclk/lrclk/sdata_in,

---
 rtl/axi_i2s_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_axi_i2s_receiver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module  : axi_i2s_receiver
// Summary : I2S slave receiver emitting one 2-beat AXI4-Stream packet per stereo frame.
// Rev     : 1.0
// ============================================================================
module axi_i2s_receiver #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 4,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_aresetn,
    input  logic                            bclk,
    input  logic                            lrclk,
    input  logic                            sdata_in,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            overflow
);
    localparam int W  = C_M_AXIS_TDATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] C_CNT_MAX   = CW'(W);
    localparam logic [CW-1:0] C_CNT_TOP   = CW'(W - 1);
    localparam logic [AW:0]   C_FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

    // Reset asserts asynchronously everywhere; release is retimed to aclk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) rst_sync_q <= 2'b00;
        else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   bclk_prev_q;
    logic                   bit_stb;
    logic                   ws_cur;
    logic                   d_cur;

    always_ff @(posedge m_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
            bclk_prev_q  <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    // lrclk/sdata run through the same depth as bclk, so they line up with the strobe.
    assign bit_stb = bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
    assign ws_cur  = lrclk_sync_q[SYNC_STAGES-1];
    assign d_cur   = sdata_sync_q[SYNC_STAGES-1];

    logic          ws_prev_q;
    logic          ws_seen_q;
    logic          framed_q;
    logic [W-1:0]  word_q;
    logic [CW-1:0] cnt_q;
    logic          ws_edge;
    logic          cnt_sat;
    logic          word_done;
    logic          word_is_right;
    logic [W-1:0]  word_shift;
    logic [W-1:0]  word_just;

    always_comb begin
        ws_edge       = bit_stb & ws_seen_q & (ws_cur != ws_prev_q);
        cnt_sat       = (cnt_q == C_CNT_MAX);
        word_shift    = {word_q[W-2:0], d_cur};
        // On a ws edge the current bit is the LSB; a saturated word has already kept its MSBs.
        word_just     = cnt_sat ? word_q : (word_shift << (C_CNT_TOP - cnt_q));
        word_done     = ws_edge & framed_q;
        word_is_right = ws_prev_q;
    end

    always_ff @(posedge m_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            ws_prev_q <= 1'b0;
            ws_seen_q <= 1'b0;
            framed_q  <= 1'b0;
            word_q    <= '0;
            cnt_q     <= '0;
        end else if (bit_stb) begin
            ws_prev_q <= ws_cur;
            ws_seen_q <= 1'b1;
            if (ws_edge) begin
                word_q   <= '0;
                cnt_q    <= '0;
                framed_q <= 1'b1;
            end else if (!cnt_sat) begin
                word_q <= word_shift;
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

    logic          stage_vld_q;
    logic [W-1:0]  stage_data_q;
    logic [W-1:0]  mem_left  [FIFO_DEPTH];
    logic [W-1:0]  mem_right [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overflow_q;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          fifo_full;
    state_t        state_q;
    state_t        state_d;

    always_comb begin
        push_req  = word_done & word_is_right & stage_vld_q;
        pop       = (state_q == S_RIGHT) & m_axis_tready;
        fifo_full = (count_q == C_FIFO_FULL);
        // A full FIFO still accepts the frame when the right beat frees the head slot this cycle.
        push      = push_req & (~fifo_full | pop);
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!push && pop) count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge m_axis_aclk) begin
        if (push) begin
            mem_left[wr_ptr_q]  <= stage_data_q;
            mem_right[wr_ptr_q] <= word_just;
        end
    end

    always_ff @(posedge m_axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= S_IDLE;
        end else begin
            if (word_done) begin
                if (!word_is_right) begin
                    stage_vld_q  <= 1'b1;
                    stage_data_q <= word_just;
                end else begin
                    stage_vld_q  <= 1'b0;
                end
            end
            if (push)            wr_ptr_q   <= wr_ptr_q + AW'(1);
            if (pop)             rd_ptr_q   <= rd_ptr_q + AW'(1);
            if (push_req && !push) overflow_q <= 1'b1;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_LEFT;
            end
            S_LEFT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = mem_left[rd_ptr_q];
                if (m_axis_tready) state_d = S_RIGHT;
            end
            S_RIGHT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = mem_right[rd_ptr_q];
                if (m_axis_tready) state_d = (count_d != '0) ? S_LEFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_i2s_receiver.sv
`default_nettype none
// Bench for axi_i2s_receiver: I2S words are played bit by bit and the stream is
// compared against a frame-level model of the word/frame rules.
module tb_axi_i2s_receiver;
    localparam int W         = 32;
    localparam int DEPTH     = 4;
    localparam int BCLK_HALF = 30;

    logic         aclk;
    logic         aresetn;
    logic         bclk;
    logic         lrclk;
    logic         sdata;
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;
    logic         ovf;

    axi_i2s_receiver #(
        .C_M_AXIS_TDATA_WIDTH(W),
        .FIFO_DEPTH          (DEPTH),
        .SYNC_STAGES         (2)
    ) dut (
        .m_axis_aclk   (aclk),
        .m_axis_aresetn(aresetn),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata_in      (sdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .overflow      (ovf)
    );

    int          checks;
    int          errors;
    bit          rand_ready;
    bit          tready_fixed;
    logic [32:0] exp_q[$];

    bit          m_first;
    bit          m_staged;
    bit          m_hold;
    bit          m_ovf;
    int          m_held;
    logic [31:0] m_stage;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : tready_fixed;
        end
    end

    function automatic logic [31:0] justify(input logic [63:0] v, input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        v = v & m;
        if (n <= 32) return 32'(v << (32 - n));
        else         return 32'(v >> (n - 32));
    endfunction

    task automatic model_word(input bit ch, input logic [63:0] v, input int n);
        if (m_first) begin
            m_first = 1'b0;
        end else if (!ch) begin
            m_staged = 1'b1;
            m_stage  = justify(v, n);
        end else begin
            if (m_staged) begin
                if (m_hold && m_held == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_q.push_back({1'b0, m_stage});
                    exp_q.push_back({1'b1, justify(v, n)});
                    m_held++;
                end
            end
            m_staged = 1'b0;
        end
    endtask

    task automatic play(input bit ws, input bit d);
        lrclk = ws;
        sdata = d;
        #(BCLK_HALF);
        bclk = 1'b1;
        #(BCLK_HALF);
        bclk = 1'b0;
    endtask

    // ws flips on the LSB slot: the standard one-bit I2S delay.
    task automatic send_word(input bit ch, input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) play((i == 0) ? ~ch : ch, v[i]);
        model_word(ch, v, n);
    endtask

    task automatic align();
        @(posedge aclk);
        #2;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge aclk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (10) @(posedge aclk);
        #1;
        checks++;
        assert (tvalid === 1'b0) else begin
            errors++;
            $error("FAIL idle_after_drain: tvalid %b, required 0", tvalid);
        end
    endtask

    task automatic check_ovf(input string tag);
        checks++;
        assert (ovf === m_ovf) else begin
            errors++;
            $error("FAIL %s: overflow %b, required %b", tag, ovf, m_ovf);
        end
    endtask

    logic         pv;
    logic         pr;
    logic         pl;
    logic [W-1:0] pd;
    logic [32:0]  exp_beat;

    always @(negedge aclk) begin
        if (!aresetn) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                checks++;
                assert (tvalid === 1'b1 && tdata === pd && tlast === pl) else begin
                    errors++;
                    $error("FAIL stall_stable: v/last/data %b/%b/%h, required 1/%b/%h",
                           tvalid, tlast, tdata, pl, pd);
                end
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL beat_unexpected: last/data %b/%h, required no beat", tlast, tdata);
                end
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    checks++;
                    assert ({tlast, tdata} === exp_beat) else begin
                        errors++;
                        $error("FAIL beat: last/data %b/%h, required %b/%h",
                               tlast, tdata, exp_beat[32], exp_beat[31:0]);
                    end
                end
            end
            pv = tvalid;
            pr = tready;
            pd = tdata;
            pl = tlast;
        end
    end

    initial begin
        logic [63:0] v;
        checks       = 0;
        errors       = 0;
        rand_ready   = 1'b0;
        tready_fixed = 1'b1;
        m_first      = 1'b1;
        m_staged     = 1'b0;
        m_hold       = 1'b0;
        m_ovf        = 1'b0;
        m_held       = 0;
        m_stage      = '0;
        aresetn      = 1'b0;
        bclk         = 1'b0;
        lrclk        = 1'b0;
        sdata        = 1'b0;

        repeat (3) @(posedge aclk);
        #2;
        checks++;
        assert ({tvalid, tlast, tdata, ovf} === {1'b0, 1'b0, 32'h0, 1'b0}) else begin
            errors++;
            $error("FAIL reset_state: v/last/data/ovf %b/%b/%h/%b, required 0/0/0/0",
                   tvalid, tlast, tdata, ovf);
        end
        aresetn = 1'b1;
        repeat (5) @(posedge aclk);
        #2;

        // first word after reset is discarded
        send_word(1'b1, 64'hC3, 8);
        send_word(1'b0, 64'hA5A50F0F, 32);
        send_word(1'b1, 64'h12345678, 32);
        drain(400);

        align();
        send_word(1'b0, 64'hABCDEF, 24);
        send_word(1'b1, 64'h000001, 24);
        send_word(1'b0, 64'hF, 4);
        send_word(1'b1, 64'h5A, 8);
        drain(400);

        align();
        send_word(1'b0, 64'h123456789A, 40);
        send_word(1'b1, 64'hFFFFFFFFFF, 40);
        drain(400);

        // random lengths and random backpressure
        rand_ready = 1'b1;
        align();
        for (int f = 0; f < 200; f++) begin
            send_word(1'b0, {$urandom, $urandom}, int'($urandom_range(4, 40)));
            send_word(1'b1, {$urandom, $urandom}, int'($urandom_range(4, 40)));
        end
        drain(2000);
        rand_ready   = 1'b0;
        tready_fixed = 1'b1;
        check_ovf("ovf_clear_random");

        // five frames into a stalled four-frame FIFO
        tready_fixed = 1'b0;
        repeat (4) @(posedge aclk);
        align();
        m_hold = 1'b1;
        m_held = 0;
        for (int f = 0; f < 5; f++) begin
            send_word(1'b0, 64'h10000000 + 64'(f), 32);
            send_word(1'b1, 64'h20000000 + 64'(f), 32);
        end
        repeat (10) @(posedge aclk);
        #1;
        check_ovf("ovf_set");
        m_hold       = 1'b0;
        tready_fixed = 1'b1;
        drain(400);
        check_ovf("ovf_sticky");

        // reset in the middle of a left word with a stalled packet pending
        tready_fixed = 1'b0;
        repeat (4) @(posedge aclk);
        align();
        send_word(1'b0, 64'h5555, 16);
        send_word(1'b1, 64'hAAAA, 16);
        repeat (10) @(posedge aclk);
        #1;
        checks++;
        assert (tvalid === 1'b1) else begin
            errors++;
            $error("FAIL pending_before_reset: tvalid %b, required 1", tvalid);
        end
        v = 64'h9ABCDE;
        for (int i = 23; i >= 19; i--) play(1'b0, v[i]);
        align();
        aresetn = 1'b0;
        #1;
        checks++;
        assert ({tvalid, tlast, tdata, ovf} === {1'b0, 1'b0, 32'h0, 1'b0}) else begin
            errors++;
            $error("FAIL reset_mid_word: v/last/data/ovf %b/%b/%h/%b, required 0/0/0/0",
                   tvalid, tlast, tdata, ovf);
        end
        exp_q.delete();
        m_first  = 1'b1;
        m_staged = 1'b0;
        m_ovf    = 1'b0;
        repeat (4) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (4) @(posedge aclk);
        align();
        for (int i = 18; i >= 0; i--) play((i == 0) ? 1'b1 : 1'b0, v[i]);
        model_word(1'b0, v, 24);
        send_word(1'b1, 64'h0F0F0, 20);
        tready_fixed = 1'b1;
        send_word(1'b0, 64'hCAFEF00D, 32);
        send_word(1'b1, 64'h00BEEF, 24);
        drain(400);
        check_ovf("ovf_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
